// File: rtl/pe_ipad_ctrl.sv
// Input-pad controller: fills a circular pad and issues sliding-window read addresses.
// Optional per-entry zero flags are built when PE_IPAD_ZSKIP_EN is defined.
module pe_ipad_ctrl #(
    parameter int unsigned IPAD_SIZE = 16,
    parameter int unsigned CONF_WD   = 8,
    localparam int unsigned AW = $clog2(IPAD_SIZE),
    localparam int unsigned OW = $clog2(IPAD_SIZE + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cont_reset,
    input  logic               i_cont_stall,
    input  logic               i_cont_start,
    input  logic [CONF_WD-1:0] i_conf_ipad_size,
    input  logic [CONF_WD-1:0] i_conf_step,
    input  logic [CONF_WD-1:0] i_conf_Tw,
    input  logic               i_ipix_valid,
    input  logic               i_ipix_zero,
    output logic               o_ipix_ready,
    output logic               o_ipad_we,
    output logic [AW-1:0]      o_ipad_waddr,
    output logic               o_ipad_re,
    output logic [AW-1:0]      o_ipad_raddr,
    output logic               o_zero_skip,
    output logic               o_last_pix,
    output logic [CONF_WD-1:0] o_opix_cnt,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_conf_err
);

    typedef enum logic [1:0] {StIdle, StInit, StLoop, StDone} state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic [AW-1:0]      base_q, base_d;
    logic [OW-1:0]      rd_off_q, rd_off_d;
    logic [OW-1:0]      occ_q, occ_d;
    logic [OW-1:0]      w_q, w_d;
    logic [OW-1:0]      d_q, d_d;
    logic [CONF_WD-1:0] tw_q, tw_d;
    logic [CONF_WD-1:0] opix_cnt_q, opix_cnt_d;
    logic               conf_err_q, conf_err_d;
    logic               conf_legal;
    logic               release_win;
    logic [AW:0]        raddr_sum;
    logic [AW:0]        base_sum;

    assign conf_legal = (i_conf_step != '0) && (i_conf_step <= i_conf_ipad_size) &&
                        (32'(i_conf_ipad_size) <= IPAD_SIZE) && (i_conf_Tw != '0);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else if (i_cont_reset) begin
            state_q <= StIdle;
        end else if (!i_cont_stall) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_cont_start && conf_legal) state_d = StInit;
            StInit:  if (occ_d == w_q) state_d = StLoop;
            StLoop:  if (opix_cnt_d == tw_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic; strobes are suppressed during a clear or stall
    always_comb begin
        o_ipix_ready = 1'b0;
        if (!i_cont_reset && !i_cont_stall && (occ_q < OW'(IPAD_SIZE))) begin
            if (state_q == StInit) begin
                o_ipix_ready = (occ_q < w_q);
            end else if (state_q == StLoop) begin
                o_ipix_ready = 1'b1;
            end
        end
        o_ipad_we = i_ipix_valid && o_ipix_ready;
        o_ipad_re = (state_q == StLoop) && (rd_off_q < occ_q) && !i_cont_stall && !i_cont_reset;
        o_last_pix = o_ipad_re && (rd_off_q == w_q - OW'(1));

        raddr_sum = {1'b0, base_q} + (AW+1)'(rd_off_q);
        if (raddr_sum >= (AW+1)'(IPAD_SIZE)) begin
            o_ipad_raddr = AW'(raddr_sum - (AW+1)'(IPAD_SIZE));
        end else begin
            o_ipad_raddr = AW'(raddr_sum);
        end

        o_ipad_waddr = waddr_q;
        o_opix_cnt   = opix_cnt_q;
        o_busy       = (state_q != StIdle);
        o_done       = (state_q == StDone);
        o_conf_err   = conf_err_q;
    end

    assign release_win = o_last_pix;

    // Datapath next-state
    always_comb begin
        waddr_d    = waddr_q;
        base_d     = base_q;
        rd_off_d   = rd_off_q;
        occ_d      = occ_q;
        w_d        = w_q;
        d_d        = d_q;
        tw_d       = tw_q;
        opix_cnt_d = opix_cnt_q;
        conf_err_d = (state_q == StIdle) && i_cont_start && !conf_legal;

        base_sum = {1'b0, base_q} + (AW+1)'(d_q);

        if (o_ipad_we) begin
            waddr_d = (waddr_q == AW'(IPAD_SIZE - 1)) ? '0 : waddr_q + AW'(1);
            occ_d   = occ_d + OW'(1);
        end
        if (o_ipad_re) begin
            rd_off_d = release_win ? '0 : rd_off_q + OW'(1);
        end
        if (release_win) begin
            occ_d      = occ_d - d_q;
            opix_cnt_d = opix_cnt_q + CONF_WD'(1);
            if (base_sum >= (AW+1)'(IPAD_SIZE)) begin
                base_d = AW'(base_sum - (AW+1)'(IPAD_SIZE));
            end else begin
                base_d = AW'(base_sum);
            end
        end

        if ((state_q == StIdle) && i_cont_start && conf_legal) begin
            w_d        = OW'(i_conf_ipad_size);
            d_d        = OW'(i_conf_step);
            tw_d       = i_conf_Tw;
            opix_cnt_d = '0;
        end
        // Pad contents are dropped when the tile finishes
        if (state_q == StDone) begin
            waddr_d  = '0;
            base_d   = '0;
            rd_off_d = '0;
            occ_d    = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            waddr_q    <= '0;
            base_q     <= '0;
            rd_off_q   <= '0;
            occ_q      <= '0;
            w_q        <= '0;
            d_q        <= '0;
            tw_q       <= '0;
            opix_cnt_q <= '0;
            conf_err_q <= 1'b0;
        end else if (i_cont_reset) begin
            waddr_q    <= '0;
            base_q     <= '0;
            rd_off_q   <= '0;
            occ_q      <= '0;
            w_q        <= '0;
            d_q        <= '0;
            tw_q       <= '0;
            opix_cnt_q <= '0;
            conf_err_q <= 1'b0;
        end else if (!i_cont_stall) begin
            waddr_q    <= waddr_d;
            base_q     <= base_d;
            rd_off_q   <= rd_off_d;
            occ_q      <= occ_d;
            w_q        <= w_d;
            d_q        <= d_d;
            tw_q       <= tw_d;
            opix_cnt_q <= opix_cnt_d;
            conf_err_q <= conf_err_d;
        end else begin
            conf_err_q <= 1'b0;
        end
    end

`ifdef PE_IPAD_ZSKIP_EN
    logic [IPAD_SIZE-1:0] zflag_q, zflag_d;

    always_comb begin
        zflag_d = zflag_q;
        if (state_q == StDone) begin
            zflag_d = '0;
        end else if (o_ipad_we) begin
            zflag_d[waddr_q] = i_ipix_zero;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            zflag_q <= '0;
        end else if (i_cont_reset) begin
            zflag_q <= '0;
        end else if (!i_cont_stall) begin
            zflag_q <= zflag_d;
        end
    end

    assign o_zero_skip = o_ipad_re && zflag_q[o_ipad_raddr];
`else
    logic unused_ipix_zero;
    assign unused_ipix_zero = i_ipix_zero;
    assign o_zero_skip      = 1'b0;
`endif

endmodule

// File: tb/tb_pe_ipad_ctrl.sv
// Self-checking bench for pe_ipad_ctrl: read/write address scoreboard plus directed checks.
module tb_pe_ipad_ctrl;

    localparam int unsigned IPAD_SIZE = 16;
    localparam int unsigned CONF_WD   = 8;
    localparam int unsigned AW        = 4;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_cont_reset;
    logic               i_cont_stall;
    logic               i_cont_start;
    logic [CONF_WD-1:0] i_conf_ipad_size;
    logic [CONF_WD-1:0] i_conf_step;
    logic [CONF_WD-1:0] i_conf_Tw;
    logic               i_ipix_valid;
    logic               i_ipix_zero;
    logic               o_ipix_ready;
    logic               o_ipad_we;
    logic [AW-1:0]      o_ipad_waddr;
    logic               o_ipad_re;
    logic [AW-1:0]      o_ipad_raddr;
    logic               o_zero_skip;
    logic               o_last_pix;
    logic [CONF_WD-1:0] o_opix_cnt;
    logic               o_busy;
    logic               o_done;
    logic               o_conf_err;

    pe_ipad_ctrl #(
        .IPAD_SIZE(IPAD_SIZE),
        .CONF_WD  (CONF_WD)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_cont_reset    (i_cont_reset),
        .i_cont_stall    (i_cont_stall),
        .i_cont_start    (i_cont_start),
        .i_conf_ipad_size(i_conf_ipad_size),
        .i_conf_step     (i_conf_step),
        .i_conf_Tw       (i_conf_Tw),
        .i_ipix_valid    (i_ipix_valid),
        .i_ipix_zero     (i_ipix_zero),
        .o_ipix_ready    (o_ipix_ready),
        .o_ipad_we       (o_ipad_we),
        .o_ipad_waddr    (o_ipad_waddr),
        .o_ipad_re       (o_ipad_re),
        .o_ipad_raddr    (o_ipad_raddr),
        .o_zero_skip     (o_zero_skip),
        .o_last_pix      (o_last_pix),
        .o_opix_cnt      (o_opix_cnt),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_conf_err      (o_conf_err)
    );

    always #5 i_clk = ~i_clk;

    // Every word written to address 3 is flagged as zero
    assign i_ipix_zero = (o_ipad_waddr == AW'(3));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int addr;
        bit last;
    } rd_t;

    rd_t rd_q[$];
    int  exp_wa = 0;
    bit  mon_en = 1'b0;

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_ipad_we) begin
                check_eq("waddr", 32'(o_ipad_waddr), exp_wa);
                exp_wa = (exp_wa + 1) % IPAD_SIZE;
            end
            if (o_ipad_re) begin
                if (rd_q.size() == 0) begin
                    check_eq("rd_extra", 32'(o_ipad_re), 0);
                end else begin
                    rd_t e;
                    int  exp_zs;
                    e = rd_q.pop_front();
`ifdef PE_IPAD_ZSKIP_EN
                    exp_zs = (e.addr == 3) ? 1 : 0;
`else
                    exp_zs = 0;
`endif
                    check_eq("raddr", 32'(o_ipad_raddr), e.addr);
                    check_eq("last_pix", 32'(o_last_pix), 32'(e.last));
                    check_eq("zero_skip", 32'(o_zero_skip), exp_zs);
                end
            end
        end
    end

    task automatic push_windows(input int w, input int d, input int tw);
        for (int k = 0; k < tw; k++) begin
            for (int j = 0; j < w; j++) begin
                rd_t e;
                e.addr = (k * d + j) % IPAD_SIZE;
                e.last = (j == w - 1);
                rd_q.push_back(e);
            end
        end
    endtask

    task automatic start_tile(input int w, input int d, input int tw);
        @(posedge i_clk);
        #1;
        i_conf_ipad_size = CONF_WD'(w);
        i_conf_step      = CONF_WD'(d);
        i_conf_Tw        = CONF_WD'(tw);
        i_cont_start     = 1'b1;
        @(posedge i_clk);
        #1;
        i_cont_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int tw);
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (o_done) break;
        end
        check_eq("done_seen", 32'(o_done), 1);
        check_eq("done_cnt", 32'(o_opix_cnt), tw);
        @(negedge i_clk);
        check_eq("done_pulse", 32'(o_done), 0);
        check_eq("idle_busy", 32'(o_busy), 0);
    endtask

    task automatic run_tile(input int w, input int d, input int tw);
        rd_q.delete();
        exp_wa       = 0;
        mon_en       = 1'b1;
        i_ipix_valid = 1'b1;
        push_windows(w, d, tw);
        start_tile(w, d, tw);
        wait_done(400, tw);
        check_eq("rd_left", rd_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int sn_wa, sn_ra, sn_cnt;
        int bad [5][3];

        i_rst            = 1'b1;
        i_cont_reset     = 1'b0;
        i_cont_stall     = 1'b0;
        i_cont_start     = 1'b0;
        i_conf_ipad_size = '0;
        i_conf_step      = '0;
        i_conf_Tw        = '0;
        i_ipix_valid     = 1'b0;

        #2;
        check_eq("rst_busy", 32'(o_busy), 0);
        check_eq("rst_ready", 32'(o_ipix_ready), 0);
        check_eq("rst_cnt", 32'(o_opix_cnt), 0);
        check_eq("rst_waddr", 32'(o_ipad_waddr), 0);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check_eq("idle_done", 32'(o_done), 0);
        check_eq("idle_err", 32'(o_conf_err), 0);

        // Basic sliding windows, then a wrapping configuration
        run_tile(6, 2, 4);
        run_tile(5, 3, 6);

        // Full pad: no input accepted while occupancy is 16
        rd_q.delete();
        exp_wa       = 0;
        mon_en       = 1'b1;
        i_ipix_valid = 1'b1;
        push_windows(16, 16, 2);
        start_tile(16, 16, 2);
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_ipad_re) break;
        end
        check_eq("full_re", 32'(o_ipad_re), 1);
        check_eq("full_ready", 32'(o_ipix_ready), 0);
        check_eq("full_we", 32'(o_ipad_we), 0);
        wait_done(200, 2);
        check_eq("full_rd_left", rd_q.size(), 0);

        // Starved reads
        rd_q.delete();
        exp_wa       = 0;
        i_ipix_valid = 1'b0;
        push_windows(4, 4, 2);
        start_tile(4, 4, 2);
        i_ipix_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(negedge i_clk);
            if (o_ipad_we) n++;
        end
        @(posedge i_clk);
        #1 i_ipix_valid = 1'b0;
        repeat (8) @(negedge i_clk);
        check_eq("starve_re", 32'(o_ipad_re), 0);
        check_eq("starve_cnt", 32'(o_opix_cnt), 1);
        check_eq("starve_raddr", 32'(o_ipad_raddr), 4);
        check_eq("starve_left", rd_q.size(), 4);
        @(posedge i_clk);
        #1 i_ipix_valid = 1'b1;
        @(negedge i_clk);
        check_eq("refill_we", 32'(o_ipad_we), 1);
        check_eq("no_overtake", 32'(o_ipad_re), 0);
        @(posedge i_clk);
        #1 i_ipix_valid = 1'b0;
        @(negedge i_clk);
        check_eq("resume_re", 32'(o_ipad_re), 1);
        check_eq("resume_raddr", 32'(o_ipad_raddr), 4);
        @(negedge i_clk);
        check_eq("restarve_re", 32'(o_ipad_re), 0);
        @(posedge i_clk);
        #1 i_ipix_valid = 1'b1;
        wait_done(50, 2);
        check_eq("starve_rd_left", rd_q.size(), 0);

        // Stall during simultaneous write and read
        mon_en       = 1'b0;
        i_ipix_valid = 1'b1;
        start_tile(6, 2, 4);
        for (int i = 0; i < 50; i++) begin
            @(negedge i_clk);
            if (o_ipad_we && o_ipad_re) break;
        end
        check_eq("both_active", 32'(o_ipad_we && o_ipad_re), 1);
        sn_wa  = 32'(o_ipad_waddr);
        sn_ra  = 32'(o_ipad_raddr);
        sn_cnt = 32'(o_opix_cnt);
        i_cont_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_we", 32'(o_ipad_we), 0);
            check_eq("stall_re", 32'(o_ipad_re), 0);
            check_eq("stall_ready", 32'(o_ipix_ready), 0);
            @(negedge i_clk);
        end
        i_cont_stall = 1'b0;
        #1;
        check_eq("post_we", 32'(o_ipad_we), 1);
        check_eq("post_re", 32'(o_ipad_re), 1);
        check_eq("post_waddr", 32'(o_ipad_waddr), sn_wa);
        check_eq("post_raddr", 32'(o_ipad_raddr), sn_ra);
        check_eq("post_cnt", 32'(o_opix_cnt), sn_cnt);
        wait_done(200, 4);

        // Illegal configurations
        bad = '{'{6, 7, 1}, '{17, 1, 1}, '{6, 0, 1}, '{6, 2, 0}, '{0, 0, 1}};
        for (int b = 0; b < 5; b++) begin
            start_tile(bad[b][0], bad[b][1], bad[b][2]);
            @(negedge i_clk);
            check_eq("err_pulse", 32'(o_conf_err), 1);
            check_eq("err_idle", 32'(o_busy), 0);
            @(negedge i_clk);
            check_eq("err_clear", 32'(o_conf_err), 0);
        end

        // Synchronous clear beats stall
        start_tile(6, 2, 4);
        repeat (10) @(posedge i_clk);
        #1;
        i_cont_stall = 1'b1;
        i_cont_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_cont_stall = 1'b0;
        i_cont_reset = 1'b0;
        @(negedge i_clk);
        check_eq("creset_busy", 32'(o_busy), 0);
        check_eq("creset_waddr", 32'(o_ipad_waddr), 0);
        check_eq("creset_cnt", 32'(o_opix_cnt), 0);

        // Asynchronous reset in window 2, then restart from address 0
        start_tile(6, 2, 4);
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            if (o_opix_cnt == CONF_WD'(2)) break;
        end
        check_eq("reach_win2", 32'(o_opix_cnt), 2);
        @(posedge i_clk);
        #3 i_rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(o_busy), 0);
        check_eq("arst_we", 32'(o_ipad_we), 0);
        check_eq("arst_re", 32'(o_ipad_re), 0);
        check_eq("arst_ready", 32'(o_ipix_ready), 0);
        check_eq("arst_cnt", 32'(o_opix_cnt), 0);
        check_eq("arst_raddr", 32'(o_ipad_raddr), 0);
        check_eq("arst_waddr", 32'(o_ipad_waddr), 0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check_eq("arst_no_done", 32'(o_done), 0);
        run_tile(4, 4, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pe_ipad_ctrl.md
PE_IPAD_CTRL -- requirements
Module: pe_ipad_ctrl

Interface
REQ-001 Parameter IPAD_SIZE, default 16: input-pad depth in words; address width AW = $clog2(IPAD_SIZE).
REQ-002 Parameter CONF_WD, default 8: width of every i_conf_* port.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 i_clk  in  1  clock; all state updates on its rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_cont_reset  in  1  synchronous clear; same effect as reset.
REQ-007 i_cont_stall  in  1  freezes all state; forces o_ipad_we, o_ipad_re and o_ipix_ready to 0.
REQ-008 i_cont_start  in  1  starts a tile; sampled only in IDLE.
REQ-009 i_conf_ipad_size  in  CONF_WD  window length W = Pch*R, in words.
REQ-010 i_conf_step  in  CONF_WD  slide step D = U*Pch, in words.
REQ-011 i_conf_Tw  in  CONF_WD  output pixels per tile.
REQ-012 i_ipix_valid  in  1  an input word is offered this cycle.
REQ-013 i_ipix_zero  in  1  the offered word is zero.
REQ-014 o_ipix_ready  out  1  the controller accepts the offered word this cycle.
REQ-015 o_ipad_we / o_ipad_waddr  out  1 / AW  write strobe and address to the pad.
REQ-016 o_ipad_re / o_ipad_raddr  out  1 / AW  read strobe and address to the pad.
REQ-017 o_zero_skip  out  1  the current read targets a zero-flagged word.
REQ-018 o_last_pix  out  1  the current read is the last word of the window.
REQ-019 o_opix_cnt  out  CONF_WD  number of windows completed.
REQ-020 o_busy / o_done / o_conf_err  out  1 each  status outputs.

Function
REQ-021 FSM states:
- IDLE: on i_cont_start, go to INIT if the configuration is legal, else stay in IDLE.
- INIT: go to LOOP when occ reaches W.
- LOOP: go to DONE when o_opix_cnt reaches Tw.
- DONE: go to IDLE after one cycle.
REQ-022 Configuration is legal when 1 <= D <= W <= IPAD_SIZE and Tw >= 1; otherwise o_conf_err = 1 for one cycle.
REQ-023 o_ipix_ready = state is INIT or LOOP, && occ < IPAD_SIZE, && !stall.
- In INIT, ready is additionally gated by occ < W.
REQ-024 Write handshake: o_ipad_we = i_ipix_valid && o_ipix_ready, issued the same cycle.
- waddr increments after each write and wraps from IPAD_SIZE-1 to 0.
REQ-025 In LOOP, o_ipad_re = 1 while rd_off < occ and !stall, where rd_off is the offset within the current window.
- o_ipad_raddr = (base + rd_off) mod IPAD_SIZE.
REQ-026 The read with rd_off = W-1 asserts o_last_pix. On the next edge:
- rd_off returns to 0;
- base advances by D (mod IPAD_SIZE);
- occ decreases by D;
- o_opix_cnt increments.
REQ-027 Occupancy: if a write and a release happen in the same cycle, occ_next = occ + 1 - D.
- occ never exceeds IPAD_SIZE and never goes below 0.
REQ-028 When a read is starved (rd_off >= occ), o_ipad_re = 0 and no pointers move. A read never overtakes a write.
REQ-029 DONE: o_done = 1 for exactly one cycle. The pad contents are dropped on return to IDLE.
REQ-030 o_busy = 1 in INIT, LOOP and DONE.
REQ-031 Read-to-data latency is fixed by the pad at 1 cycle. This block issues addresses only.
REQ-032 i_cont_reset takes priority over i_cont_stall, which takes priority over normal operation.

Reset
REQ-033 On i_rst or i_cont_reset:
- state = IDLE;
- all pointers, occ and o_opix_cnt = 0;
- every output = 0;
- all zero flags = 0.
REQ-034 A reset in the middle of a tile abandons it. No o_done is produced.

Configuration
REQ-035 Macro PE_IPAD_ZSKIP_EN.
- Defined: a per-entry flag register of IPAD_SIZE bits is written with i_ipix_zero on each write. o_zero_skip = flag[o_ipad_raddr] when o_ipad_re = 1.
- Undefined: the flag register is absent and o_zero_skip is tied to 0.

Verification
REQ-036 Config W=6, D=2, Tw=4, valid held high:
- INIT fills addresses 0-5;
- window 0 reads 0-5 with o_last_pix on the read of 5;
- window 1 reads 2-7;
- o_done occurs after 4 windows, with o_opix_cnt = 4.
REQ-037 Config W=16, D=16, IPAD_SIZE=16:
- o_ipix_ready = 0 while occ = 16;
- reads wrap from 15 to 0 correctly in the second window.
REQ-038 Drop i_ipix_valid during LOOP so occ = rd_off:
- o_ipad_re = 0 and no pointers change;
- reads resume the cycle after the next write.
REQ-039 Assert i_cont_stall for 3 cycles during simultaneous write and read:
- all strobes = 0 during the stall;
- all state is identical before and after the stall.
REQ-040 Config D=7, W=6 with i_cont_start:
- o_conf_err = 1 for 1 cycle;
- state remains IDLE.
REQ-041 Assert i_rst during window 2:
- all outputs = 0 immediately, without waiting for a clock edge;
- a subsequent start refills from waddr 0.
- With PE_IPAD_ZSKIP_EN defined, a zero word at address 3 gives o_zero_skip = 1 only on reads of address 3.
